// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIRECT   = 2'd1,
        UART_WAIT  = 2'd2,
        ST_INVALID = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [4:0]  REG_X0   = 5'd0;
    localparam int          WAIT_W   = 10;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator (load in execute feeding a source of the decode instruction)
//   ex_mem_read, ex_rd            : execute instruction is a load to ex_rd
//   id_rs1/2, id_rs1/2_used       : decode instruction sources and whether they are read
//   load_use                      : decode must wait one cycle for the load result
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       load_use
);

    // x0 is hard-wired zero, so a load to it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                      ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for redirects, load-use hazards and blocking UART loads
//   clk, rst (sync, active-high)  : clock and reset; all outputs read 0 while rst=1
//   id_*, ex_rd, ex_mem_read      : hazard detection inputs
//   take_branch, jump             : redirect resolved in execute
//   uart_load, uart_ready         : blocking UART load in execute and its data-valid
//   stall_if, stall_pipe          : hold PC / hold all pipeline registers
//   flush_fd, flush_dx            : inject NOP into fetch/decode, decode/execute registers
//   uart_req, uart_timeout, state : UART request, forced-release pulse, current state encoding
//   stall_cycles, flush_count     : performance counters, present only with HAZARD_PERF_CNT_EN defined
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int UART_TIMEOUT = 1023
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        take_branch,
    input  logic        jump,
    input  logic        uart_load,
    input  logic        uart_ready,
    output logic        stall_if,
    output logic        stall_pipe,
    output logic        flush_fd,
    output logic        flush_dx,
    output logic        uart_req,
    output logic        uart_timeout,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(UART_TIMEOUT);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                load_use;
    logic                redirect;
    logic                timeout_hit;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .load_use    (load_use)
    );

    assign redirect    = take_branch || jump;
    assign timeout_hit = wait_cnt_q == TIMEOUT_V;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    state_d = REDIRECT;
                end else if (uart_load) begin
                    state_d    = UART_WAIT;
                    wait_cnt_d = '0;
                end
            end
            REDIRECT: state_d = RUN;
            UART_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (uart_ready || timeout_hit) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_if     = 1'b0;
        stall_pipe   = 1'b0;
        flush_fd     = 1'b0;
        flush_dx     = 1'b0;
        uart_req     = 1'b0;
        uart_timeout = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (redirect) begin
                        flush_fd = 1'b1;
                        flush_dx = 1'b1;
                    end else if (uart_load) begin
                        stall_if   = 1'b1;
                        stall_pipe = 1'b1;
                        uart_req   = 1'b1;
                    end else if (load_use) begin
                        // single bubble: hold fetch/decode, let execute drain
                        stall_if = 1'b1;
                        flush_dx = 1'b1;
                    end
                end
                REDIRECT: flush_fd = 1'b1;
                UART_WAIT: begin
                    uart_req = 1'b1;
                    // ready takes precedence over a coincident timeout
                    uart_timeout = !uart_ready && timeout_hit;
                    stall_if     = !uart_ready && !timeout_hit;
                    stall_pipe   = !uart_ready && !timeout_hit;
                end
                default: ;
            endcase
        end
    end

    assign state = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_if && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush_fd && flush_count_q != '1) flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles = rst ? 32'd0 : stall_cycles_q;
    assign flush_count  = rst ? 32'd0 : flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter UART_TIMEOUT, default 1023, max UART_WAIT cycles before forced release (range 1..1023).
REQ-002 SHALL have ports clk in 1 (clock); rst in 1 (reset, synchronous, active-high).
REQ-003 SHALL have ports id_rs1 in 5, id_rs2 in 5 (source registers of instruction in decode).
REQ-004 SHALL have ports id_rs1_used in 1, id_rs2_used in 1 (decode instruction reads that source).
REQ-005 SHALL have ports ex_rd in 5, ex_mem_read in 1 (execute instruction is a load to ex_rd).
REQ-006 SHALL have ports take_branch in 1, jump in 1 (redirect resolved in execute).
REQ-007 SHALL have ports uart_load in 1 (execute instruction is a UART load), uart_ready in 1 (UART data valid).
REQ-008 SHALL have outputs stall_if out 1 (hold PC), stall_pipe out 1 (hold all pipeline registers), flush_fd out 1 (NOP into fetch/decode register), flush_dx out 1 (NOP into decode/execute register).
REQ-009 SHALL have outputs uart_req out 1, uart_timeout out 1, state out 2.
REQ-010 SHALL have outputs stall_cycles out 32, flush_count out 32.

Function
REQ-011 SHALL implement states RUN=0, REDIRECT=1, UART_WAIT=2; encoding 3 unused, SHALL recover to RUN next cycle with all outputs 0.
REQ-012 Load-use hazard SHALL be ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-013 Outputs SHALL be combinational from state and current inputs (zero latency); state SHALL update on posedge clk.
REQ-014 RUN priority: redirect > uart_load > load-use > none.
REQ-015 RUN, take_branch|jump: flush_fd=1, flush_dx=1, stalls 0; next REDIRECT.
REQ-016 RUN, uart_load (no redirect): stall_if=1, stall_pipe=1, uart_req=1; UART wait counter cleared to 0; next UART_WAIT.
REQ-017 RUN, load-use only: stall_if=1, flush_dx=1, stall_pipe=0 (one bubble); stay RUN.
REQ-018 REDIRECT: flush_fd=1 (covers one-cycle imem latency), all else 0; redirect/uart/hazard inputs ignored; next RUN.
REQ-019 UART_WAIT: uart_req=1; counter increments by 1 per cycle.
REQ-020 UART_WAIT, uart_ready=1: stalls 0 that cycle (pipeline captures UART data); next RUN.
REQ-021 UART_WAIT, no ready, counter==UART_TIMEOUT: uart_timeout=1 for exactly one cycle, stalls 0; next RUN.
REQ-022 UART_WAIT, otherwise: stall_if=1, stall_pipe=1; stay.
REQ-023 uart_ready and timeout in same cycle: ready wins, uart_timeout=0.
REQ-024 uart_ready outside UART_WAIT SHALL be ignored.
REQ-025 state output SHALL equal the current encoding.

Reset
REQ-026 While rst=1: state<=RUN, counter<=0, counters<=0; all outputs forced 0 that cycle regardless of inputs.
REQ-027 rst in REDIRECT or UART_WAIT SHALL abort immediately, no uart_timeout pulse.

Configuration
REQ-028 With HAZARD_PERF_CNT_EN defined: stall_cycles +1 each cycle stall_if=1; flush_count +1 each cycle flush_fd=1; both saturate at 32'hFFFF_FFFF.
REQ-029 Without HAZARD_PERF_CNT_EN: stall_cycles, flush_count tied 0, no counter flops.

Structure
REQ-030 Shared package pipeline_ctrl_pkg SHALL hold state enum, NOP_INST=32'h0000_0013, REG_X0=5'd0.
REQ-031 Load-use comparator SHALL be sub-module hazard_detect (combinational, REQ-012).

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle stall_if=1, flush_dx=1, stall_pipe=0; state stays 0.
REQ-033 Same with ex_rd=0 -> all outputs 0.
REQ-034 take_branch=1 with uart_load=1 in RUN -> flush_fd=flush_dx=1, uart_req=0; next cycle state=1, flush_fd=1; then state=0.
REQ-035 uart_load=1, uart_ready after 3 wait cycles -> stall_pipe=1 for 4 cycles, 0 on ready cycle, uart_timeout never 1.
REQ-036 UART_TIMEOUT=4, uart_ready held 0 -> uart_timeout=1 one cycle at counter 4, state returns 0; with ready asserted at the same cycle -> uart_timeout=0.
REQ-037 rst=1 mid UART_WAIT -> outputs 0 same cycle, state=0 next; HAZARD_PERF_CNT_EN: stall_cycles reads 0 after reset.
